// File: rtl/nv_rf4x128_fifo_ctl.sv
//------------------------------------------------------------------------------
// nv_rf4x128_fifo_ctl
//
// Purpose: flow-control sequencer that turns an external 4 x 128-bit two-port
// register-file RAM into an 8-deep valid/ready FIFO. The RAM read path is two
// registered stages (re = address register, ore = output register). A 4-entry
// flop skid buffer absorbs that latency so the consumer can pop every cycle.
//
// Ports:
//   nvdla_core_clk   in   sole clock
//   nvdla_core_rstn  in   synchronous active-low reset
//   wr_pvld/wr_prdy  in/out producer handshake, wr_pd = 128-bit payload
//   rd_pvld/rd_prdy  out/in consumer handshake, rd_pd = skid head
//   ram_we/ram_wa/ram_di      RAM write port
//   ram_re/ram_ra             RAM read-address register enable / address
//   ram_ore                   RAM output register enable
//   ram_dout         in   RAM registered read data
//   fifo_cnt         out  entries held (0..8)
//   fifo_idle        out  nothing held and no read in flight
//
// Build option: define NV_RF4X128_FIFO_BYPASS_EN to let a write go straight
// into the skid buffer when the RAM and the read pipeline are empty.
//------------------------------------------------------------------------------
module nv_rf4x128_fifo_ctl (
   input  logic         nvdla_core_clk,
   input  logic         nvdla_core_rstn,
   input  logic         wr_pvld,
   output logic         wr_prdy,
   input  logic [127:0] wr_pd,
   output logic         rd_pvld,
   input  logic         rd_prdy,
   output logic [127:0] rd_pd,
   output logic         ram_we,
   output logic [1:0]   ram_wa,
   output logic [127:0] ram_di,
   output logic         ram_re,
   output logic [1:0]   ram_ra,
   output logic         ram_ore,
   input  logic [127:0] ram_dout,
   output logic [3:0]   fifo_cnt,
   output logic         fifo_idle
);

   localparam int DATA_W = 128;

   logic [1:0]        wptr_q, wptr_d;
   logic [1:0]        rptr_q, rptr_d;
   logic [2:0]        ram_used_q, ram_used_d;   // slots written, not yet past O
   logic [2:0]        unissued_q, unissued_d;   // slots written, read not yet issued
   logic              o_vld_q, o_vld_d;         // a word is in its O cycle
   logic              l_vld_q, l_vld_d;         // a word is in its L cycle
   logic [1:0]        skid_head_q, skid_head_d;
   logic [1:0]        skid_tail_q, skid_tail_d;
   logic [2:0]        skid_cnt_q, skid_cnt_d;
   logic [DATA_W-1:0] skid_mem_q [4];
   logic [DATA_W-1:0] skid_mem_d [4];

   logic              wr_acc;
   logic              bypass;
   logic              ram_wr;
   logic              issue;
   logic              pop;
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic [2:0]        credit_used;

   always_comb begin
      // Registered state only: keeps the producer ready path free of rd_prdy.
      wr_prdy = nvdla_core_rstn && (ram_used_q < 3'd4);
      wr_acc  = wr_pvld && wr_prdy;

`ifdef NV_RF4X128_FIFO_BYPASS_EN
      // Safe for ordering: nothing older can be sitting in RAM or in flight.
      bypass = wr_acc && (ram_used_q == 3'd0) && !o_vld_q && !l_vld_q &&
               (skid_cnt_q < 3'd4);
`else
      bypass = 1'b0;
`endif
      ram_wr = wr_acc && !bypass;

      // Every word in O or L already owns a skid slot; issuing reserves one
      // more, so the skid buffer can never be overrun when data lands.
      credit_used = skid_cnt_q + {2'b00, o_vld_q} + {2'b00, l_vld_q};
      issue       = (unissued_q != 3'd0) && (credit_used < 3'd4);

      rd_pvld   = (skid_cnt_q != 3'd0);
      pop       = rd_pvld && rd_prdy;
      push      = l_vld_q || bypass;
      push_data = l_vld_q ? ram_dout : wr_pd;
   end

   always_comb begin
      wptr_d      = wptr_q + {1'b0, ram_wr};
      rptr_d      = rptr_q + {1'b0, issue};
      // Slot is released in its O cycle; a same-cycle write may reuse it
      // because ore captures the old data on the edge that commits the write.
      ram_used_d  = ram_used_q + {2'b00, ram_wr} - {2'b00, o_vld_q};
      unissued_d  = unissued_q + {2'b00, ram_wr} - {2'b00, issue};
      o_vld_d     = issue;
      l_vld_d     = o_vld_q;
      skid_head_d = skid_head_q + {1'b0, pop};
      skid_tail_d = skid_tail_q + {1'b0, push};
      skid_cnt_d  = skid_cnt_q + {2'b00, push} - {2'b00, pop};
      skid_mem_d  = skid_mem_q;
      if (push) begin
         skid_mem_d[skid_tail_q] = push_data;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         wptr_q      <= 2'd0;
         rptr_q      <= 2'd0;
         ram_used_q  <= 3'd0;
         unissued_q  <= 3'd0;
         o_vld_q     <= 1'b0;
         l_vld_q     <= 1'b0;
         skid_head_q <= 2'd0;
         skid_tail_q <= 2'd0;
         skid_cnt_q  <= 3'd0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         ram_used_q  <= ram_used_d;
         unissued_q  <= unissued_d;
         o_vld_q     <= o_vld_d;
         l_vld_q     <= l_vld_d;
         skid_head_q <= skid_head_d;
         skid_tail_q <= skid_tail_d;
         skid_cnt_q  <= skid_cnt_d;
      end
   end

   // Payload storage carries no reset; validity comes from skid_cnt_q.
   always_ff @(posedge nvdla_core_clk) begin
      skid_mem_q <= skid_mem_d;
   end

   always_comb begin
      ram_we    = ram_wr;
      ram_wa    = wptr_q;
      ram_di    = wr_pd;
      ram_re    = issue;
      ram_ra    = rptr_q;
      ram_ore   = o_vld_q;
      rd_pd     = skid_mem_q[skid_head_q];
      // Words in O are still counted in ram_used; words in L are counted here.
      fifo_cnt  = {1'b0, ram_used_q} + {3'b000, l_vld_q} + {1'b0, skid_cnt_q};
      fifo_idle = (fifo_cnt == 4'd0) && !o_vld_q && !l_vld_q;
   end

endmodule

// File: tb/tb_nv_rf4x128_fifo_ctl.sv
module tb_nv_rf4x128_fifo_ctl;

   logic         clk;
   logic         rstn;
   logic         wr_pvld;
   logic         wr_prdy;
   logic [127:0] wr_pd;
   logic         rd_pvld;
   logic         rd_prdy;
   logic [127:0] rd_pd;
   logic         ram_we;
   logic [1:0]   ram_wa;
   logic [127:0] ram_di;
   logic         ram_re;
   logic [1:0]   ram_ra;
   logic         ram_ore;
   logic [127:0] ram_dout;
   logic [3:0]   fifo_cnt;
   logic         fifo_idle;

   int n_chk  = 0;
   int n_fail = 0;
   int n_acc  = 0;
   int n_pop  = 0;

   logic [127:0] sb [$];
   logic [1:0]   exp_wa;
   logic [1:0]   exp_ra;

   localparam logic [127:0] T1_WORD = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_0001;

   nv_rf4x128_fifo_ctl dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wr_pvld         (wr_pvld),
      .wr_prdy         (wr_prdy),
      .wr_pd           (wr_pd),
      .rd_pvld         (rd_pvld),
      .rd_prdy         (rd_prdy),
      .rd_pd           (rd_pd),
      .ram_we          (ram_we),
      .ram_wa          (ram_wa),
      .ram_di          (ram_di),
      .ram_re          (ram_re),
      .ram_ra          (ram_ra),
      .ram_ore         (ram_ore),
      .ram_dout        (ram_dout),
      .fifo_cnt        (fifo_cnt),
      .fifo_idle       (fifo_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the external two-port RAM with its two read registers.
   logic [127:0] ram_mem [4];
   logic [1:0]   ram_ra_r;
   always @(posedge clk) begin
      if (ram_we)  ram_mem[ram_wa] <= ram_di;
      if (ram_re)  ram_ra_r <= ram_ra;
      if (ram_ore) ram_dout <= ram_mem[ram_ra_r];
   end

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] word(input logic [31:0] tag, input int idx);
      return {tag, 64'h0123_4567_89AB_CDEF, 32'(idx)};
   endfunction

   // Scoreboard monitor: accepted words are queued, popped words compared.
   initial begin
      exp_wa = 2'd0;
      exp_ra = 2'd0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            sb.delete();
            exp_wa = 2'd0;
            exp_ra = 2'd0;
            chk("prdy_in_reset", 128'(wr_prdy), 128'd0);
         end else begin
            chk("fifo_cnt", 128'(fifo_cnt), 128'(sb.size()));
            chk("cnt_le_8", 128'(fifo_cnt <= 4'd8), 128'd1);
`ifndef NV_RF4X128_FIFO_BYPASS_EN
            chk("ram_we", 128'(ram_we), 128'(wr_pvld && wr_prdy));
`endif
            if (ram_we) begin
               chk("ram_wa", 128'(ram_wa), 128'(exp_wa));
               chk("ram_di", ram_di, wr_pd);
               exp_wa = exp_wa + 2'd1;
            end
            if (ram_re) begin
               chk("ram_ra", 128'(ram_ra), 128'(exp_ra));
               exp_ra = exp_ra + 2'd1;
            end
            if (rd_pvld && rd_prdy) begin
               n_pop++;
               if (sb.size() == 0) chk("pop_unexpected", 128'd1, 128'd0);
               else chk("rd_pd", rd_pd, sb.pop_front());
            end
            if (wr_pvld && wr_prdy) begin
               n_acc++;
               sb.push_back(wr_pd);
            end
         end
      end
   end

   task automatic do_reset();
      rstn    = 1'b0;
      wr_pvld = 1'b0;
      step();
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_wr_prdy", 128'(wr_prdy), 128'd1);
      chk("rst_rd_pvld", 128'(rd_pvld), 128'd0);
      chk("rst_ram_en", 128'({ram_we, ram_re, ram_ore}), 128'd0);
      chk("rst_ptrs", 128'({ram_wa, ram_ra}), 128'd0);
      chk("rst_cnt", 128'(fifo_cnt), 128'd0);
      chk("rst_idle", 128'(fifo_idle), 128'd1);
      step();
   endtask

   task automatic drain(input int max_cyc);
      int c;
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      c = 0;
      while (sb.size() != 0 && c < max_cyc) begin
         @(negedge clk);
         c++;
      end
      repeat (5) @(negedge clk);
      chk("drain_empty", 128'(sb.size()), 128'd0);
      chk("drain_idle", 128'(fifo_idle), 128'd1);
      step();
   endtask

   // Offer n words (one per cycle, advancing only on acceptance), count accepts.
   task automatic offer(input logic [31:0] tag, input int n, output int nacc);
      nacc = 0;
      for (int i = 0; i < n; i++) begin
         wr_pvld = 1'b1;
         wr_pd   = word(tag, i);
         @(negedge clk);
         if (wr_prdy) nacc++;
         step();
      end
      wr_pvld = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc;
      int sent;
      int cyc;
      int started;
      logic acc;
      logic pp;

      rstn    = 1'b0;
      wr_pvld = 1'b0;
      rd_prdy = 1'b0;
      wr_pd   = '0;

      // Single word latency.
      do_reset();
      rd_prdy = 1'b1;
      wr_pvld = 1'b1;
      wr_pd   = T1_WORD;
      @(negedge clk);                                 // W
`ifdef NV_RF4X128_FIFO_BYPASS_EN
      chk("t1_we_bypass", 128'(ram_we), 128'd0);
      step();
      wr_pvld = 1'b0;
      @(negedge clk);                                 // W+1
      chk("t1_vld_w1", 128'(rd_pvld), 128'd1);
      chk("t1_data", rd_pd, T1_WORD);
      @(negedge clk);                                 // W+2
      chk("t1_cnt_after", 128'(fifo_cnt), 128'd0);
`else
      chk("t1_we", 128'(ram_we), 128'd1);
      chk("t1_wa", 128'(ram_wa), 128'd0);
      step();
      wr_pvld = 1'b0;
      @(negedge clk);                                 // W+1
      chk("t1_re", 128'(ram_re), 128'd1);
      chk("t1_ra", 128'(ram_ra), 128'd0);
      chk("t1_cnt", 128'(fifo_cnt), 128'd1);
      chk("t1_busy", 128'(fifo_idle), 128'd0);
      @(negedge clk);                                 // W+2
      chk("t1_ore", 128'(ram_ore), 128'd1);
      chk("t1_vld_w2", 128'(rd_pvld), 128'd0);
      @(negedge clk);                                 // W+3
      chk("t1_vld_w3", 128'(rd_pvld), 128'd0);
      @(negedge clk);                                 // W+4
      chk("t1_vld_w4", 128'(rd_pvld), 128'd1);
      chk("t1_data", rd_pd, T1_WORD);
      @(negedge clk);                                 // W+5
      chk("t1_cnt_after", 128'(fifo_cnt), 128'd0);
`endif
      step();
      drain(50);

      // Fill with consumer stalled: 8 of 10 accepted, then drain in order.
      do_reset();
      rd_prdy = 1'b0;
      offer(32'h0000_0002, 10, nacc);
      chk("t2_accepted", 128'(nacc), 128'd8);
      @(negedge clk);
      chk("t2_prdy_full", 128'(wr_prdy), 128'd0);
      chk("t2_cnt_full", 128'(fifo_cnt), 128'd8);
      step();
      drain(100);
      @(negedge clk);
      chk("t2_prdy_back", 128'(wr_prdy), 128'd1);
      step();

      // Streaming: once output starts, one accept and one pop every cycle.
      do_reset();
      rd_prdy = 1'b1;
      wr_pvld = 1'b1;
      sent = 0; cyc = 0; started = 0;
      wr_pd = word(32'h0000_0003, 0);
      while (sent < 100 && cyc < 1000) begin
         @(negedge clk);
         acc = wr_pvld && wr_prdy;
         pp  = rd_pvld && rd_prdy;
         if (pp) started = 1;
         if (started != 0) begin
            chk("t3_accept", 128'(acc), 128'd1);
            chk("t3_pop", 128'(pp), 128'd1);
         end
         if (acc) sent++;
         step();
         wr_pd = word(32'h0000_0003, sent);
         cyc++;
      end
      chk("t3_sent", 128'(sent), 128'd100);
      drain(100);

      // Slot reuse with pointers starting at 2: slot 2 is rewritten while
      // the older data from slot 2 is still on its way to the consumer.
      do_reset();
      rd_prdy = 1'b1;
      offer(32'h0000_0004, 2, nacc);
      drain(50);
      rd_prdy = 1'b0;
      offer(32'h0000_0044, 10, nacc);
      chk("t4_accepted", 128'(nacc), 128'd8);
      drain(100);

      // Reset with five words held.
      do_reset();
      rd_prdy = 1'b0;
      offer(32'h0000_0005, 5, nacc);
      @(negedge clk);
      chk("t5_cnt_before", 128'(fifo_cnt), 128'd5);
      step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("t5_cnt_after", 128'(fifo_cnt), 128'd0);
      chk("t5_vld_after", 128'(rd_pvld), 128'd0);
      step();
      wr_pvld = 1'b1;
      wr_pd   = word(32'h0000_0055, 77);
      @(negedge clk);
`ifndef NV_RF4X128_FIFO_BYPASS_EN
      chk("t5_wa", 128'(ram_wa), 128'd0);
`endif
      chk("t5_accept", 128'(wr_prdy), 128'd1);
      step();
      drain(50);

      // Random consumer stalls over 1000 words.
      do_reset();
      sent = 0; cyc = 0;
      n_acc = 0; n_pop = 0;
      while (sent < 1000 && cyc < 20000) begin
         wr_pvld = ($urandom_range(0, 3) != 0);
         rd_prdy = $urandom_range(0, 1) != 0;
         wr_pd   = word(32'h0000_0006, sent);
         @(negedge clk);
         if (wr_pvld && wr_prdy) sent++;
         step();
         cyc++;
      end
      chk("t6_sent", 128'(sent), 128'd1000);
      drain(200);
      chk("t6_no_loss", 128'(n_pop), 128'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
